// File: rtl/seq_div_8by4_if.sv
// Start/done handshake and operand/result bundle for the 8-by-4 sequential divider.
interface seq_div_8by4_if #(
   parameter int unsigned DIVIDEND_W = 8,
   parameter int unsigned DIVISOR_W  = 4
);
   logic                  start;
   logic [DIVIDEND_W-1:0] dividend;
   logic [DIVISOR_W-1:0]  divisor;
   logic [DIVIDEND_W-1:0] quot;
   logic [DIVISOR_W-1:0]  rem;
   logic                  busy;
   logic                  done;
   logic                  div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  quot, rem, busy, done, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output quot, rem, busy, done, div_by_zero
   );
endinterface

// File: rtl/seq_div_8by4.sv
// Sequential restoring divider: one quotient bit per clock, MSB first,
// start/done handshake, divide-by-zero reported on the accepting edge.
module seq_div_8by4 #(
   parameter int unsigned DIVIDEND_W = 8,
   parameter int unsigned DIVISOR_W  = 4
) (
   input logic           clk,
   input logic           rst_n,
   seq_div_8by4_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(DIVIDEND_W);
   localparam int unsigned PR_W  = DIVISOR_W + 1;
   localparam int unsigned T_W   = DIVISOR_W + 2;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                state_q, state_d;
   logic [PR_W-1:0]       pr_q, pr_d;
   logic [DIVIDEND_W-1:0] q_q, q_d;
   logic [DIVISOR_W-1:0]  d_q, d_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DIVIDEND_W-1:0] quot_q, quot_d;
   logic [DIVISOR_W-1:0]  rem_q, rem_d;
   logic                  dbz_q, dbz_d;
   logic                  done_q, done_d;

   logic                  zero_req;
   logic                  accept;
   logic                  last_step;
   logic [T_W-1:0]        t;
   logic [T_W-1:0]        diff;
   logic                  ge;
   logic [PR_W-1:0]       pr_step;
   logic [DIVIDEND_W-1:0] q_step;

   // Decode the incoming request and the final iteration
   always_comb begin
      zero_req  = (bus.divisor == '0);
      accept    = (state_q == IDLE) && bus.start && !zero_req;
      last_step = (cnt_q == LAST_STEP);
   end

   // One restoring step; pr_q's top bit is always 0, so widening t by it lets
   // the subtraction's borrow bit double as the compare result.
   always_comb begin
      t       = {pr_q, q_q[DIVIDEND_W-1]};
      diff    = t - {2'b00, d_q};
      ge      = ~diff[T_W-1];
      pr_step = ge ? diff[PR_W-1:0] : t[PR_W-1:0];
      q_step  = {q_q[DIVIDEND_W-2:0], ge};
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state: enter RUN on an accepted nonzero divide, leave after the last step
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept)    state_d = RUN;
         RUN:  if (last_step) state_d = IDLE;
         default:             state_d = IDLE;
      endcase
   end

   // Datapath and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pr_q   <= '0;
         q_q    <= '0;
         d_q    <= '0;
         cnt_q  <= '0;
         quot_q <= '0;
         rem_q  <= '0;
         dbz_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         pr_q   <= pr_d;
         q_q    <= q_d;
         d_q    <= d_d;
         cnt_q  <= cnt_d;
         quot_q <= quot_d;
         rem_q  <= rem_d;
         dbz_q  <= dbz_d;
         done_q <= done_d;
      end
   end

   // Datapath next-state: load operands, iterate, publish results
   always_comb begin
      pr_d   = pr_q;
      q_d    = q_q;
      d_d    = d_q;
      cnt_d  = cnt_q;
      quot_d = quot_q;
      rem_d  = rem_q;
      dbz_d  = dbz_q;
      done_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (zero_req) begin
                  quot_d = '1;
                  rem_d  = bus.dividend[DIVISOR_W-1:0];
                  dbz_d  = 1'b1;
                  done_d = 1'b1;
               end else begin
                  q_d   = bus.dividend;
                  d_d   = bus.divisor;
                  pr_d  = '0;
                  cnt_d = '0;
                  dbz_d = 1'b0;
               end
            end
         end
         RUN: begin
            pr_d  = pr_step;
            q_d   = q_step;
            cnt_d = cnt_q + 1'b1;
            if (last_step) begin
               quot_d = q_step;
               rem_d  = pr_step[DIVISOR_W-1:0];
               done_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // FSM outputs and registered results onto the bus
   always_comb begin
      bus.busy        = (state_q == RUN);
      bus.done        = done_q;
      bus.quot        = quot_q;
      bus.rem         = rem_q;
      bus.div_by_zero = dbz_q;
   end

endmodule

// File: tb/tb_seq_div_8by4.sv
// Directed and exhaustive bench for seq_div_8by4 with a result scoreboard.
module tb_seq_div_8by4;

   localparam int unsigned DW = 8;
   localparam int unsigned VW = 4;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   seq_div_8by4_if #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) bus ();

   seq_div_8by4 #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [7:0] dd;
      logic [3:0] dv;
      logic [7:0] q;
      logic [3:0] r;
      logic       z;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
         $error("check %s observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic push_exp(input logic [7:0] dd, input logic [3:0] dv);
      exp_t e;
      e.dd = dd;
      e.dv = dv;
      if (dv == 4'd0) begin
         e.q = 8'hFF;
         e.r = dd[3:0];
         e.z = 1'b1;
      end else begin
         e.q = dd / {4'd0, dv};
         e.r = 4'(dd % {4'd0, dv});
         e.z = 1'b0;
      end
      exp_q.push_back(e);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_quot"}, bus.quot, 0);
      chk({tag, "_rem"},  bus.rem, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_done"}, bus.done, 0);
      chk({tag, "_dbz"},  bus.div_by_zero, 0);
   endtask

   // Present one request for a single accepting edge.
   task automatic issue(input logic [7:0] dd, input logic [3:0] dv);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = dd;
      bus.divisor  = dv;
      push_exp(dd, dv);
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   // Wait (bounded) for done, checking busy each cycle before it, then score the result.
   task automatic wait_result(input int exp_lat, input bit exp_busy, input bit interfere);
      int   n    = 0;
      bit   seen = 1'b0;
      exp_t e;
      while (!seen && n < 20) begin
         @(negedge clk);
         n++;
         if (interfere && n == 2) begin
            bus.start    = 1'b1;
            bus.dividend = 8'd50;
            bus.divisor  = 4'd10;
         end
         if (interfere && n == 6) bus.start = 1'b0;
         if (bus.done === 1'b1) seen = 1'b1;
         else chk("busy_run", bus.busy, exp_busy);
      end
      chk("done_seen", seen, 1);
      chk("latency", n, exp_lat);
      if (seen && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("quot", bus.quot, e.q);
         chk("rem", bus.rem, e.r);
         chk("dbz", bus.div_by_zero, e.z);
         chk("busy_at_done", bus.busy, 0);
         @(negedge clk);
         chk("done_pulse", bus.done, 0);
         chk("hold_quot", bus.quot, e.q);
         chk("hold_rem", bus.rem, e.r);
      end
   endtask

   initial begin
      int         n;
      bit         seen;
      exp_t       e;
      int         nxt;
      logic [7:0] ndd;
      logic [3:0] ndv;

      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (2) @(negedge clk);
      chk_reset_vals("reset");
      rst_n = 1'b1;

      issue(8'd143, 4'd9);  wait_result(9, 1'b1, 1'b0);
      issue(8'd255, 4'd1);  wait_result(9, 1'b1, 1'b0);
      issue(8'd5,   4'd15); wait_result(9, 1'b1, 1'b0);
      issue(8'd0,   4'd7);  wait_result(9, 1'b1, 1'b0);

      issue(8'd200, 4'd0);  wait_result(1, 1'b0, 1'b0);
      issue(8'd117, 4'd13); wait_result(9, 1'b1, 1'b0);

      issue(8'd42, 4'd7);   wait_result(9, 1'b1, 1'b1);
      repeat (2) begin
         @(negedge clk);
         chk("ignored_start", bus.busy, 0);
      end

      issue(8'd98, 4'd14);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("rst_async");
      exp_q.delete();
      repeat (3) begin
         @(negedge clk);
         chk("rst_no_done", bus.done, 0);
      end
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("rst_idle_busy", bus.busy, 0);
         chk("rst_idle_done", bus.done, 0);
      end
      issue(8'd98, 4'd14); wait_result(9, 1'b1, 1'b0);

      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 8'd0;
      bus.divisor  = 4'd1;
      push_exp(8'd0, 4'd1);
      for (int i = 0; i < 3840; i++) begin
         n    = 0;
         seen = 1'b0;
         while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (bus.done === 1'b1) seen = 1'b1;
         end
         chk("b2b_done", seen, 1);
         chk("b2b_interval", n, 9);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("b2b_quot", bus.quot, e.q);
            chk("b2b_rem", bus.rem, e.r);
            chk("b2b_identity", 32'(bus.quot) * 32'(e.dv) + 32'(bus.rem), 32'(e.dd));
            chk("b2b_rem_lt", 32'(bus.rem < e.dv), 1);
         end
         if (i < 3839) begin
            nxt          = i + 1;
            ndd          = 8'(nxt / 15);
            ndv          = 4'(nxt % 15 + 1);
            bus.dividend = ndd;
            bus.divisor  = ndv;
            push_exp(ndd, ndv);
         end else begin
            bus.start = 1'b0;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
